// File: rtl/alu_share_arbiter_if.sv
// Request, ALU and response bundle for the shared-ALU arbiter.
// The slave modport is the arbiter side. The master modport is the side of the requesters, the ALU and the consumer.
interface alu_share_arbiter_if #(
    parameter int DATA_W = 64,
    parameter int OP_W   = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_a;
    logic [DATA_W-1:0] req0_b;
    logic [OP_W-1:0]   req0_op;
    logic              req1_valid;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_a;
    logic [DATA_W-1:0] req1_b;
    logic [OP_W-1:0]   req1_op;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [OP_W-1:0]   alu_op;
    logic [DATA_W-1:0] alu_result;
    logic              alu_overflow;
    logic              rsp_valid;
    logic              rsp_ready;
    logic              rsp_id;
    logic [DATA_W-1:0] rsp_data;
    logic              rsp_overflow;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req0_ready, req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result, alu_overflow,
        output rsp_valid, rsp_id, rsp_data, rsp_overflow,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req0_ready, req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result, alu_overflow,
        input  rsp_valid, rsp_id, rsp_data, rsp_overflow,
        output rsp_ready
    );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin time-sharing of one ex_stage ALU between execute (port 0) and address calc (port 1).
// Optional ALU_SHARE_ARBITER_B2B_EN: allow a grant in RESP when rsp_ready is high (2-cycle issue interval).
module alu_share_arbiter #(
    parameter int              DATA_W  = 64,
    parameter int              OP_W    = 4,
    parameter logic [OP_W-1:0] IDLE_OP = {OP_W{1'b1}}
) (
    input  logic               clk,
    input  logic               rst_n,
    alu_share_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t            state, state_nxt;
    logic              rr_ptr;
    logic              grant_en, grant_id, hs;
    logic [DATA_W-1:0] lat_a, lat_b;
    logic [OP_W-1:0]   lat_op;
    logic              lat_id;
    logic              rsp_valid_q, rsp_id_q, rsp_ovf_q;
    logic [DATA_W-1:0] rsp_data_q;

    always_comb begin
        grant_en = (state == IDLE);
`ifdef ALU_SHARE_ARBITER_B2B_EN
        if (state == RESP && bus.rsp_ready) grant_en = 1'b1;
`endif
        // A tie goes to rr_ptr. Otherwise the grant goes to whichever port is valid.
        if (bus.req0_valid && bus.req1_valid) grant_id = rr_ptr;
        else                                  grant_id = bus.req1_valid;
        hs             = grant_en && (bus.req0_valid || bus.req1_valid);
        bus.req0_ready = hs && !grant_id;
        bus.req1_ready = hs && grant_id;

        state_nxt = state;
        case (state)
            IDLE:    if (hs) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (bus.rsp_ready) state_nxt = hs ? EXEC : IDLE;
            default: state_nxt = IDLE;
        endcase

        bus.alu_a  = '0;
        bus.alu_b  = '0;
        bus.alu_op = IDLE_OP;
        if (state == EXEC) begin
            bus.alu_a  = lat_a;
            bus.alu_b  = lat_b;
            bus.alu_op = lat_op;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            rr_ptr      <= 1'b0;
            lat_a       <= '0;
            lat_b       <= '0;
            lat_op      <= IDLE_OP;
            lat_id      <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= 1'b0;
            rsp_data_q  <= '0;
            rsp_ovf_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (hs) begin
                lat_id <= grant_id;
                lat_a  <= grant_id ? bus.req1_a  : bus.req0_a;
                lat_b  <= grant_id ? bus.req1_b  : bus.req0_b;
                lat_op <= grant_id ? bus.req1_op : bus.req0_op;
            end
            if (state == EXEC) begin
                rsp_data_q  <= bus.alu_result;
                rsp_ovf_q   <= bus.alu_overflow;
                rsp_id_q    <= lat_id;
                rsp_valid_q <= 1'b1;
                rr_ptr      <= ~lat_id;
            end else if (state == RESP && bus.rsp_ready) begin
                rsp_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rsp_valid    = rsp_valid_q;
    assign bus.rsp_id       = rsp_id_q;
    assign bus.rsp_data     = rsp_data_q;
    assign bus.rsp_overflow = rsp_ovf_q;
endmodule

// File: tb/tb_alu_share_arbiter.sv
// Bench for alu_share_arbiter: a vector table, hand-written corner sequences and a response scoreboard.
// It also models the external ALU combinationally.
module tb_alu_share_arbiter;
    localparam int DATA_W = 64;
    localparam int OP_W   = 4;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b1000;
    localparam logic [3:0] OP_NOP = 4'b1111;
`ifdef ALU_SHARE_ARBITER_B2B_EN
    localparam int B2B = 1;
    localparam int GAP = 2;
`else
    localparam int B2B = 0;
    localparam int GAP = 3;
`endif

    typedef struct packed {
        logic        id;
        logic [63:0] data;
        logic        ovf;
    } rsp_t;

    typedef struct {
        bit          id;
        logic [63:0] a;
        logic [63:0] b;
        logic [3:0]  op;
        logic [63:0] data;
        bit          ovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    alu_share_arbiter_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();
    alu_share_arbiter #(.DATA_W(DATA_W), .OP_W(OP_W), .IDLE_OP(OP_NOP)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Stand-in for ex_stage
    logic [63:0] sum, diff;
    assign sum  = bus.alu_a + bus.alu_b;
    assign diff = bus.alu_a - bus.alu_b;
    always_comb begin
        bus.alu_result   = '0;
        bus.alu_overflow = 1'b0;
        case (bus.alu_op)
            OP_ADD: begin
                bus.alu_result   = sum;
                bus.alu_overflow = (bus.alu_a[63] == bus.alu_b[63]) && (sum[63] != bus.alu_a[63]);
            end
            OP_SUB: begin
                bus.alu_result   = diff;
                bus.alu_overflow = (bus.alu_a[63] != bus.alu_b[63]) && (diff[63] != bus.alu_a[63]);
            end
            OP_SLT:  bus.alu_result = {63'd0, $signed(bus.alu_a) < $signed(bus.alu_b)};
            default: ;
        endcase
    end

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    rsp_t sb_q[$];
    rsp_t exp0, exp1, got;
    int   gnt_id_q[$];
    int   gnt_cyc_q[$];
    vec_t vecs[8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: push on request handshake, pop on response handshake
    always @(negedge clk) begin
        if (!rst_n) begin
            sb_q.delete();
        end else begin
            check("ready_onehot", {63'd0, bus.req0_ready & bus.req1_ready}, 64'd0);
            if (bus.req0_valid && bus.req0_ready) begin
                sb_q.push_back(exp0); gnt_id_q.push_back(0); gnt_cyc_q.push_back(cyc);
            end
            if (bus.req1_valid && bus.req1_ready) begin
                sb_q.push_back(exp1); gnt_id_q.push_back(1); gnt_cyc_q.push_back(cyc);
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb_q.size() == 0) begin
                    n_cmp++; n_bad++;
                    $display("FAIL rsp_unexpected: got id %0d data %h expected no response",
                             bus.rsp_id, bus.rsp_data);
                end else begin
                    got = sb_q.pop_front();
                    check("rsp_id",  {63'd0, bus.rsp_id}, {63'd0, got.id});
                    check("rsp_data", bus.rsp_data, got.data);
                    check("rsp_ovf", {63'd0, bus.rsp_overflow}, {63'd0, got.ovf});
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_reqs();
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = OP_NOP;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = OP_NOP;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_reqs();
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic drive(input bit id, input logic [63:0] a, input logic [63:0] b, input logic [3:0] op,
                         input logic [63:0] data, input bit ovf);
        if (id) begin
            exp1.id = 1'b1; exp1.data = data; exp1.ovf = ovf;
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b; bus.req1_op = op;
        end else begin
            exp0.id = 1'b0; exp0.data = data; exp0.ovf = ovf;
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b; bus.req0_op = op;
        end
    endtask

    task automatic drain(input string nm);
        int k = 0;
        while ((sb_q.size() != 0 || bus.rsp_valid) && k < 30) begin
            @(negedge clk);
            k++;
        end
        check(nm, 64'(sb_q.size()), 64'd0);
    endtask

    // One isolated operation. Ends at the negedge where the response is handshaked.
    task automatic run_one(input vec_t v);
        step();
        drive(v.id, v.a, v.b, v.op, v.data, v.ovf);
        @(negedge clk);
        check("req_ready", {63'd0, v.id ? bus.req1_ready : bus.req0_ready}, 64'd1);
        check("idle_alu_op", {60'd0, bus.alu_op}, {60'd0, OP_NOP});
        step();
        clear_reqs();
        bus.req0_a = ~v.a; bus.req1_a = ~v.a; bus.req0_op = OP_ADD; bus.req1_op = OP_ADD;
        @(negedge clk);
        check("exec_alu_op", {60'd0, bus.alu_op}, {60'd0, v.op});
        check("exec_alu_a", bus.alu_a, v.a);
        check("exec_alu_b", bus.alu_b, v.b);
        check("exec_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
        @(negedge clk);
        check("rsp_latency", {63'd0, bus.rsp_valid}, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{0, 64'd5, 64'd7, OP_ADD, 64'd12, 0};
        vecs[1] = '{1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, OP_ADD, 64'h8000_0000_0000_0000, 1};
        vecs[2] = '{0, 64'd10, 64'd3, OP_SUB, 64'd7, 0};
        vecs[3] = '{1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, OP_SLT, 64'd1, 0};
        vecs[4] = '{0, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, OP_SLT, 64'd0, 0};
        vecs[5] = '{1, 64'd123, 64'd456, OP_NOP, 64'd0, 0};
        vecs[6] = '{0, 64'd0, 64'd1, OP_SUB, 64'hFFFF_FFFF_FFFF_FFFF, 0};
        vecs[7] = '{1, 64'h8000_0000_0000_0000, 64'd1, OP_SUB, 64'h7FFF_FFFF_FFFF_FFFF, 1};

        bus.rsp_ready = 1'b0;
        clear_reqs();

        // Reset and idle state
        do_reset();
        @(negedge clk);
        check("rst_rsp_valid", {63'd0, bus.rsp_valid}, 64'd0);
        check("rst_rsp_data", bus.rsp_data, 64'd0);
        check("rst_rsp_id", {63'd0, bus.rsp_id}, 64'd0);
        check("rst_rsp_ovf", {63'd0, bus.rsp_overflow}, 64'd0);
        check("rst_alu_op", {60'd0, bus.alu_op}, {60'd0, OP_NOP});
        check("rst_alu_a", bus.alu_a, 64'd0);
        check("rst_ready0", {63'd0, bus.req0_ready}, 64'd0);
        check("rst_ready1", {63'd0, bus.req1_ready}, 64'd0);

        // Table of isolated operations
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) run_one(vecs[i]);
        drain("vec_drain");

        // Both ports continuously valid: grants must alternate
        do_reset();
        gnt_id_q.delete();
        gnt_cyc_q.delete();
        drive(0, 64'd10, 64'd3, OP_SUB, 64'd7, 0);
        drive(1, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, OP_SLT, 64'd1, 0);
        for (int k = 0; k < 60 && gnt_id_q.size() < 6; k++) @(negedge clk);
        step();
        clear_reqs();
        drain("rr_drain");
        check("rr_grants", {63'd0, gnt_id_q.size() >= 6}, 64'd1);
        for (int k = 0; k < 6 && k < gnt_id_q.size(); k++) begin
            check("rr_order", 64'(gnt_id_q[k]), 64'(k % 2));
            if (k > 0) check("rr_interval", 64'(gnt_cyc_q[k] - gnt_cyc_q[k-1]), 64'(GAP));
        end

        // Backpressure with a pending request on port 1
        do_reset();
        bus.rsp_ready = 1'b0;
        drive(0, 64'd5, 64'd7, OP_ADD, 64'd12, 0);
        @(negedge clk);
        check("bp_ready0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        clear_reqs();
        drive(1, 64'd20, 64'd5, OP_SUB, 64'd15, 0);
        @(negedge clk);
        check("bp_exec_ready1", {63'd0, bus.req1_ready}, 64'd0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("bp_valid", {63'd0, bus.rsp_valid}, 64'd1);
            check("bp_data", bus.rsp_data, 64'd12);
            check("bp_id", {63'd0, bus.rsp_id}, 64'd0);
            check("bp_ready1", {63'd0, bus.req1_ready}, 64'd0);
            check("bp_ready0", {63'd0, bus.req0_ready}, 64'd0);
        end
        step();
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready1", {63'd0, bus.req1_ready}, 64'(B2B));
        step();
        if (B2B == 0) begin
            @(negedge clk);
            check("bp_idle_ready1", {63'd0, bus.req1_ready}, 64'd1);
            step();
        end
        clear_reqs();
        drain("bp_drain");

        // Reset during EXEC discards the op and clears rr_ptr
        do_reset();
        run_one(vecs[0]);
        step();
        drive(0, 64'd9, 64'd4, OP_SUB, 64'd5, 0);
        @(negedge clk);
        check("mid_ready0", {63'd0, bus.req0_ready}, 64'd1);
        step();
        clear_reqs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("mid_no_rsp", {63'd0, bus.rsp_valid}, 64'd0);
            check("mid_alu_idle", {60'd0, bus.alu_op}, {60'd0, OP_NOP});
        end
        step();
        drive(0, 64'd1, 64'd1, OP_ADD, 64'd2, 0);
        drive(1, 64'd3, 64'd3, OP_ADD, 64'd6, 0);
        @(negedge clk);
        check("mid_rr_ready0", {63'd0, bus.req0_ready}, 64'd1);
        check("mid_rr_ready1", {63'd0, bus.req1_ready}, 64'd0);
        step();
        clear_reqs();
        drain("mid_drain");

        check("final_sb_empty", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
